// File: rtl/pipelined_adder_pkg.sv
// Shared constants and per-stage control payload for the chunked pipelined adder.
package pipelined_adder_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef struct packed {
        logic carry;
        logic sub;
    } stage_ctrl_t;
endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/pipelined_adder_stage.sv
// CW-bit ripple adder from fulladder cells; also exposes the carry into its MSB.
module adder_stage #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_c,
    output logic [CW-1:0] o_s,
    output logic          o_c,
    output logic          o_msb_c
);
    logic [CW:0] w_c;

    assign w_c[0] = i_c;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        fulladder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_s[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_c     = w_c[CW];
    assign o_msb_c = w_c[CW-1];
endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipelined over STAGES chunks with valid/ready handshake per stage.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_upv;
    logic [STAGES-1:0] w_ld;
    logic [STAGES:0]   w_rdy;
    logic [WIDTH-1:0]  w_bx;

    assign w_bx = Sub ? ~B : B;

    // A stage can take a beat when empty or when its own beat leaves this cycle.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = !r_vld[k] || w_rdy[k+1];
        end
    end

    always_comb begin
        w_upv    = '0;
        w_upv[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_upv[k] = r_vld[k-1];
        end
    end

    assign w_ld = w_rdy[STAGES-1:0] & w_upv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= (w_rdy[STAGES-1:0] & w_upv) | (~w_rdy[STAGES-1:0] & r_vld);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;

        logic [CW-1:0]    w_a;
        logic [CW-1:0]    w_b;
        logic [CW-1:0]    w_s;
        logic             w_ci;
        logic             w_sub;
        logic             w_co;
        logic             w_msb_ci;
        logic [LO+CW-1:0] w_sum_nx;
        logic [LO+CW-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a      = A[CW-1:0];
            assign w_b      = w_bx[CW-1:0];
            assign w_ci     = Cin ^ Sub;
            assign w_sub    = Sub;
            assign w_sum_nx = w_s;
        end else begin : g_src
            assign w_a      = g_stage[k-1].g_mid.r_a[CW-1:0];
            assign w_b      = g_stage[k-1].g_mid.r_bx[CW-1:0];
            assign w_ci     = g_stage[k-1].g_mid.r_ctl.carry;
            assign w_sub    = g_stage[k-1].g_mid.r_ctl.sub;
            assign w_sum_nx = {w_s, g_stage[k-1].r_sum};
        end

        adder_stage #(.CW(CW)) u_add (
            .i_a     (w_a),
            .i_b     (w_b),
            .i_c     (w_ci),
            .o_s     (w_s),
            .o_c     (w_co),
            .o_msb_c (w_msb_ci)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum <= '0;
            end else if (w_ld[k]) begin
                r_sum <= w_sum_nx;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            localparam int PW = WIDTH - LO - CW;

            logic [PW-1:0] w_pa;
            logic [PW-1:0] w_pb;
            logic [PW-1:0] r_a;
            logic [PW-1:0] r_bx;
            stage_ctrl_t   r_ctl;
            logic          w_unused;

            // Overflow only matters at the MSB chunk.
            assign w_unused = w_msb_ci;

            if (k == 0) begin : g_pend
                assign w_pa = A[WIDTH-1:CW];
                assign w_pb = w_bx[WIDTH-1:CW];
            end else begin : g_pend
                assign w_pa = g_stage[k-1].g_mid.r_a[PW+CW-1:CW];
                assign w_pb = g_stage[k-1].g_mid.r_bx[PW+CW-1:CW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_bx  <= '0;
                    r_ctl <= '0;
                end else if (w_ld[k]) begin
                    r_a   <= w_pa;
                    r_bx  <= w_pb;
                    r_ctl <= '{carry: w_co, sub: w_sub};
                end
            end
        end else begin : g_last
            logic r_cout;
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_ld[k]) begin
                    r_cout <= w_co ^ w_sub;
                    r_ovf  <= w_msb_ci ^ w_co;
                end
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_vld[STAGES-1];
    assign Sum       = g_stage[STAGES-1].r_sum;
    assign Cout      = g_stage[STAGES-1].g_last.r_cout;
    assign Ovf       = g_stage[STAGES-1].g_last.r_ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector, backpressure, reset and random-traffic checks for pipelined_adder.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        Sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        Ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];
    logic [17:0] q[$];

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference computed from arithmetic values, returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [16:0] u;
        logic [15:0] s;
        logic        c;
        int          r;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        if (!sub) begin
            u = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            s = u[15:0];
            c = u[16];
            r = sa + sb + int'(cin);
        end else begin
            s = a - b - {15'd0, cin};
            c = ({1'b0, a} < ({1'b0, b} + {16'd0, cin}));
            r = sa - sb - int'(cin);
        end
        return {(r > 32767 || r < -32768), c, s};
    endfunction

    initial begin
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b1, 1'b0};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[10] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_outputs", {14'd0, Ovf, Cout, Sum}, 32'd0);

        // Directed vectors, one beat at a time, with latency check.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int lat;
            @(negedge clk);
            A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin; Sub = vecs[i].sub;
            in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
            chk($sformatf("vec%0d_result", i), {14'd0, Ovf, Cout, Sum},
                {14'd0, vecs[i].ovf, vecs[i].cout, vecs[i].sum});
            @(negedge clk);
        end

        // Backpressure: continuous offers while downstream stalls.
        begin
            int          acc;
            int          n;
            logic [15:0] held;
            logic        seen;
            acc = 0; n = 0; seen = 1'b0; held = '0;
            q.delete();
            @(negedge clk);
            out_ready = 1'b0;
            for (int c = 0; c < 8; c++) begin
                A = 16'(16'h1001 * (n + 1)); B = 16'h0101; Cin = 1'b0; Sub = 1'b0;
                in_valid = 1'b1;
                #1;
                if (out_valid && !seen) begin
                    seen = 1'b1;
                    held = Sum;
                end
                if (in_ready) begin
                    q.push_back(model(A, B, Cin, Sub));
                    acc++;
                    n++;
                end
                @(negedge clk);
            end
            #1;
            chk("bp_accepted", acc, 32'd4);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum_stable", {16'd0, Sum}, {16'd0, held});
            in_valid = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                logic [17:0] e;
                #1;
                e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                chk($sformatf("bp_drain%0d_valid", i), {31'd0, out_valid}, 32'd1);
                chk($sformatf("bp_drain%0d_result", i), {14'd0, Ovf, Cout, Sum}, {14'd0, e});
                @(negedge clk);
            end
            #1;
            chk("bp_empty", {31'd0, out_valid}, 32'd0);
        end

        // Reset with beats in flight.
        begin
            int stale;
            @(negedge clk);
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                A = 16'(i + 5); B = 16'h0010; Cin = 1'b0; Sub = 1'b0;
                in_valid = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid_now", {31'd0, out_valid}, 32'd0);
            chk("rst_sum_clear", {14'd0, Ovf, Cout, Sum}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            out_ready = 1'b1;
            #1;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            stale = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                #1;
                if (out_valid) stale++;
            end
            chk("rst_no_stale", stale, 32'd0);
        end

        // Random traffic against the arithmetic model.
        begin
            int          sent;
            int          guard;
            logic        stall;
            logic [17:0] held;
            sent = 0; guard = 0; stall = 1'b0; held = '0;
            q.delete();
            while ((sent < 10000 || q.size() > 0) && guard < 60000) begin
                @(negedge clk);
                guard++;
                if (stall) chk("rnd_hold", {14'd0, Ovf, Cout, Sum}, {14'd0, held});
                A = 16'($urandom); B = 16'($urandom);
                Cin = 1'($urandom); Sub = 1'($urandom);
                in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid && out_ready) begin
                    logic [17:0] e;
                    e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                    chk("rnd_result", {14'd0, Ovf, Cout, Sum}, {14'd0, e});
                end
                stall = out_valid && !out_ready;
                held = {Ovf, Cout, Sum};
                if (in_valid && in_ready) begin
                    q.push_back(model(A, B, Cin, Sub));
                    sent++;
                end
            end
            chk("rnd_completed", {31'd0, (guard < 60000)}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
